// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator.
// Combinational grant back to inputs, registered crossbar select.
module switch_allocator_rr #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2,
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]          switch_request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0]  out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0]  downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]          on_off_i,
    output logic [PORT_NUM-1:0]                      valid_sel_o,
    output logic [PORT_NUM-1:0][VW-1:0]              vc_sel_o,
    output logic [PORT_NUM-1:0][PW-1:0]              xbar_sel_o,
    output logic [PORT_NUM-1:0]                      xbar_valid_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
    logic [PORT_NUM-1:0][VW-1:0]     in_ptr;
    logic [PORT_NUM-1:0][PW-1:0]     out_ptr;
    logic [PORT_NUM-1:0]             nom_valid;
    logic [PORT_NUM-1:0][VW-1:0]     win_vc;
    logic [PORT_NUM-1:0][PW-1:0]     nom_port;
    logic [PORT_NUM-1:0]             in_gnt;
    logic [PORT_NUM-1:0]             out_gnt;
    logic [PORT_NUM-1:0][PW-1:0]     out_sel;

    // Out-of-range ports or downstream VCs are silently masked.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (switch_request_i[i][v] &&
                    int'(out_port_i[i][v]) < PORT_NUM &&
                    int'(downstream_vc_i[i][v]) < VC_NUM)
                    elig[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
            end
        end
    end

    always_comb begin
        nom_valid = '0;
        win_vc    = '0;
        nom_port  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (!nom_valid[i] && elig[i][v] &&
                        v == (int'(in_ptr[i]) + k) % VC_NUM) begin
                        nom_valid[i] = 1'b1;
                        win_vc[i]    = VW'(v);
                        nom_port[i]  = out_port_i[i][v];
                    end
                end
            end
        end
    end

    always_comb begin
        out_gnt = '0;
        out_sel = '0;
        in_gnt  = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                for (int j = 0; j < PORT_NUM; j++) begin
                    if (!out_gnt[o] && nom_valid[j] &&
                        nom_port[j] == PW'(o) &&
                        j == (int'(out_ptr[o]) + k) % PORT_NUM) begin
                        out_gnt[o] = 1'b1;
                        out_sel[o] = PW'(j);
                        in_gnt[j]  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        valid_sel_o = '0;
        vc_sel_o    = '0;
        if (!rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                valid_sel_o[i] = in_gnt[i];
                vc_sel_o[i]    = in_gnt[i] ? win_vc[i] : '0;
            end
        end
    end

    // Only final grants advance pointers; stage-2 losers keep priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ptr       <= '0;
            out_ptr      <= '0;
            xbar_valid_o <= '0;
            xbar_sel_o   <= '0;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (in_gnt[i])
                    in_ptr[i] <= (int'(win_vc[i]) == VC_NUM - 1) ?
                                 '0 : win_vc[i] + 1'b1;
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                if (out_gnt[o]) begin
                    out_ptr[o]    <= (int'(out_sel[o]) == PORT_NUM - 1) ?
                                     '0 : out_sel[o] + 1'b1;
                    xbar_sel_o[o] <= out_sel[o];
                end
            end
            xbar_valid_o <= out_gnt;
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench for switch_allocator_rr.
// Each step drives inputs after a falling edge and samples before the rising edge.
module tb_switch_allocator_rr;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int PW = 3;
    localparam int VW = 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [P-1:0][V-1:0]           req;
    logic [P-1:0][V-1:0][PW-1:0]   out_port;
    logic [P-1:0][V-1:0][VW-1:0]   dvc;
    logic [P-1:0][V-1:0]           on_off;
    logic [P-1:0]                  valid_sel;
    logic [P-1:0][VW-1:0]          vc_sel;
    logic [P-1:0][PW-1:0]          xbar_sel;
    logic [P-1:0]                  xbar_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_allocator_rr #(.PORT_NUM(P), .VC_NUM(V)) dut (
        .clk              (clk),
        .rst              (rst),
        .switch_request_i (req),
        .out_port_i       (out_port),
        .downstream_vc_i  (dvc),
        .on_off_i         (on_off),
        .valid_sel_o      (valid_sel),
        .vc_sel_o         (vc_sel),
        .xbar_sel_o       (xbar_sel),
        .xbar_valid_o     (xbar_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        req      = '0;
        out_port = '0;
        dvc      = '0;
        on_off   = '1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_in[6];
        exp_in = '{0, 1, 4, 0, 1, 4};

        // Reset held two cycles with every VC requesting output 0
        rst = 1'b1;
        clr();
        req = '1;
        #1 chk("rst_c1_valid", 32'(valid_sel), 32'd0);
        @(negedge clk);
        chk("rst_c2_valid", 32'(valid_sel), 32'd0);
        @(negedge clk);
        chk("rst_c3_valid", 32'(valid_sel), 32'd0);
        chk("rst_xvalid", 32'(xbar_valid), 32'd0);
        chk("rst_xsel", 32'(xbar_sel), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_first_valid", 32'(valid_sel), 32'b00001);
        chk("rst_first_vc", 32'(vc_sel), 32'd0);
        @(negedge clk);
        clr();
        chk("rst_first_xvalid", 32'(xbar_valid), 32'b00001);
        chk("rst_first_xsel0", 32'(xbar_sel[0]), 32'd0);

        // Single request: input 2 VC 1 to output 3
        do_reset();
        req[2][1]      = 1'b1;
        out_port[2][1] = 3'd3;
        dvc[2][1]      = 1'b0;
        #1;
        chk("single_valid", 32'(valid_sel), 32'b00100);
        chk("single_vc", 32'(vc_sel), 32'b00100);
        @(negedge clk);
        clr();
        chk("single_xvalid", 32'(xbar_valid), 32'b01000);
        chk("single_xsel3", 32'(xbar_sel[3]), 32'd2);
        #1 chk("single_idle", 32'(valid_sel), 32'd0);

        // Output contention: inputs 0, 1, 4 all to output 2
        do_reset();
        req[0][0] = 1'b1; out_port[0][0] = 3'd2;
        req[1][0] = 1'b1; out_port[1][0] = 3'd2;
        req[4][0] = 1'b1; out_port[4][0] = 3'd2;
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("cont_valid_%0d", c), 32'(valid_sel),
                   32'(1 << exp_in[c]));
            @(negedge clk);
            chk($sformatf("cont_xsel_%0d", c), 32'(xbar_sel[2]),
                32'(exp_in[c]));
            chk($sformatf("cont_xvalid_%0d", c), 32'(xbar_valid),
                32'b00100);
        end

        // VC alternation on input 1
        do_reset();
        req[1]      = 2'b11;
        out_port[1] = '0;
        dvc[1][0]   = 1'b0;
        dvc[1][1]   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("vcalt_valid_%0d", c), 32'(valid_sel), 32'b00010);
            chk($sformatf("vcalt_vc_%0d", c), 32'(vc_sel[1]), 32'(c % 2));
            @(negedge clk);
        end

        // Stage-2 loss: input 3 keeps its VC pointer after losing
        do_reset();
        req[0][0] = 1'b1; out_port[0][0] = 3'd1;
        req[3][0] = 1'b1; out_port[3][0] = 3'd1;
        req[3][1] = 1'b1; out_port[3][1] = 3'd2;
        #1 chk("loss_c1_valid", 32'(valid_sel), 32'b00001);
        @(negedge clk);
        chk("loss_c1_xvalid", 32'(xbar_valid), 32'b00010);
        chk("loss_c1_xsel1", 32'(xbar_sel[1]), 32'd0);
        #1;
        chk("loss_c2_valid", 32'(valid_sel), 32'b01000);
        chk("loss_c2_vc3", 32'(vc_sel[3]), 32'd0);
        @(negedge clk);
        chk("loss_c2_xsel1", 32'(xbar_sel[1]), 32'd3);
        chk("loss_c2_xvalid", 32'(xbar_valid), 32'b00010);

        // Flow control blocks until on_off rises
        do_reset();
        on_off[4][1] = 1'b0;
        req[0][0] = 1'b1; out_port[0][0] = 3'd4; dvc[0][0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("fc_block_%0d", c), 32'(valid_sel), 32'd0);
            @(negedge clk);
            chk($sformatf("fc_xvalid_%0d", c), 32'(xbar_valid), 32'd0);
        end
        on_off[4][1] = 1'b1;
        #1 chk("fc_open", 32'(valid_sel), 32'b00001);
        @(negedge clk);
        chk("fc_xsel4", 32'(xbar_sel[4]), 32'd0);
        chk("fc_xvalid", 32'(xbar_valid), 32'b10000);

        // Out-of-range port is masked
        do_reset();
        req[2][0] = 1'b1; out_port[2][0] = 3'd7;
        req[2][1] = 1'b1; out_port[2][1] = 3'd5;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("mask_%0d", c), 32'(valid_sel), 32'd0);
            @(negedge clk);
            chk($sformatf("mask_xvalid_%0d", c), 32'(xbar_valid), 32'd0);
        end

        // Mid-stream reset restores index-0 priority
        do_reset();
        req[0][0] = 1'b1; out_port[0][0] = 3'd2;
        req[1][0] = 1'b1; out_port[1][0] = 3'd2;
        req[4][0] = 1'b1; out_port[4][0] = 3'd2;
        #1 chk("mid_g0", 32'(valid_sel), 32'b00001);
        @(negedge clk);
        #1 chk("mid_g1", 32'(valid_sel), 32'b00010);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_valid", 32'(valid_sel), 32'd0);
        @(negedge clk);
        chk("mid_rst_xvalid", 32'(xbar_valid), 32'd0);
        rst = 1'b0;
        #1 chk("mid_after", 32'(valid_sel), 32'b00001);
        @(negedge clk);
        chk("mid_after_xsel2", 32'(xbar_sel[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
